vga_sync_gen: RTL



---
 rtl/vga_timing_pkg.sv | 26 ++
 rtl/pix_tick_gen.sv | 31 +++
 rtl/vga_sync_gen.sv | 103 ++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and helpers for the pong display path.
// The graphics generator takes its MAX_X/MAX_Y from here as well.
package vga_timing_pkg;

    localparam int HD = 640;
    localparam int HF = 16;
    localparam int HR = 96;
    localparam int HB = 48;
    localparam int VD = 480;
    localparam int VF = 10;
    localparam int VR = 2;
    localparam int VB = 33;
    localparam int HT = HD + HF + HR + HB;
    localparam int VT = VD + VF + VR + VB;

    localparam int MAX_X   = HD;
    localparam int MAX_Y   = VD;
    localparam int COORD_W = 10;
    localparam int RGB_W   = 3;

    // True when c lies in [lo, lo+len-1].
    function automatic logic in_window(input logic [COORD_W-1:0] c, input int lo, input int len);
        return (int'(c) >= lo) && (int'(c) < lo + len);
    endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// Divides the system clock into a one-clk pixel enable every CLK_DIV cycles.
module pix_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    output logic p_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             div_last;

    // With CLK_DIV=1 the counter sits at 0 and the tick is permanently high.
    assign div_last = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    assign p_tick   = div_last;

    always_comb begin
        div_cnt_d = div_last ? '0 : div_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate h/v counters, sync decode, and registered
// colour/sync outputs so all connector signals lag pix_x/pix_y by one pixel.
module vga_sync_gen #(
    parameter int HD       = vga_timing_pkg::HD,
    parameter int HF       = vga_timing_pkg::HF,
    parameter int HR       = vga_timing_pkg::HR,
    parameter int HB       = vga_timing_pkg::HB,
    parameter int VD       = vga_timing_pkg::VD,
    parameter int VF       = vga_timing_pkg::VF,
    parameter int VR       = vga_timing_pkg::VR,
    parameter int VB       = vga_timing_pkg::VB,
    parameter int CLK_DIV  = 2,
    parameter bit SYNC_ACT = 1'b0
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [vga_timing_pkg::RGB_W-1:0]    rgb_in,
    output logic                                hsync,
    output logic                                vsync,
    output logic [vga_timing_pkg::RGB_W-1:0]    rgb_out,
    output logic                                video_on,
    output logic                                p_tick,
    output logic [vga_timing_pkg::COORD_W-1:0]  pix_x,
    output logic [vga_timing_pkg::COORD_W-1:0]  pix_y,
    output logic                                frame_start
);

    import vga_timing_pkg::*;

    localparam int H_TOT = HD + HF + HR + HB;
    localparam int V_TOT = VD + VF + VR + VB;

    logic                 tick;
    logic [COORD_W-1:0]   h_cnt_q, h_cnt_d;
    logic [COORD_W-1:0]   v_cnt_q, v_cnt_d;
    logic                 hsync_q, hsync_d;
    logic                 vsync_q, vsync_d;
    logic [RGB_W-1:0]     rgb_q, rgb_d;
    logic                 frame_start_q, frame_start_d;
    logic                 h_end, v_end, vid;

    pix_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .p_tick  (tick)
    );

    assign h_end = (h_cnt_q == COORD_W'(H_TOT - 1));
    assign v_end = (v_cnt_q == COORD_W'(V_TOT - 1));
    assign vid   = (int'(h_cnt_q) < HD) && (int'(v_cnt_q) < VD);

    // Sync and colour describe the pixel being left on this tick, hence one pixel of lag.
    always_comb begin
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        rgb_d         = rgb_q;
        frame_start_d = 1'b0;
        if (tick) begin
            if (h_end) begin
                h_cnt_d       = '0;
                v_cnt_d       = v_end ? '0 : v_cnt_q + 1'b1;
                frame_start_d = v_end;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
            hsync_d = in_window(h_cnt_q, HD + HF, HR) ? SYNC_ACT : ~SYNC_ACT;
            vsync_d = in_window(v_cnt_q, VD + VF, VR) ? SYNC_ACT : ~SYNC_ACT;
            rgb_d   = vid ? rgb_in : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hsync_q       <= ~SYNC_ACT;
            vsync_q       <= ~SYNC_ACT;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_x       = h_cnt_q;
    assign pix_y       = v_cnt_q;
    assign video_on    = vid;
    assign p_tick      = tick;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgb_out     = rgb_q;
    assign frame_start = frame_start_q;

endmodule
